// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Iterative unsigned multiply/divide unit that sits beside the ALU in the
// execute stage. An accepted command runs WIDTH shift-add (multiply) or
// restoring-subtract (divide) iterations while holding the pipeline frozen.
// The result is presented in a one-cycle DONE state, during which the
// pipeline advances.
//
// Ports:
//   clk     sole clock, rising edge
//   rst     synchronous active-high reset
//   start   EXE instruction is a mul/div op (held while it sits in EXE)
//   op      00 MULU low, 01 MULU high, 10 DIVU quotient, 11 DIVU remainder
//   a, b    forwarded operands, sampled only on acceptance
//   flush   abort the current operation / block acceptance
//   busy    high while iterating
//   freeze  combinational pipeline stall request
//   done    one-cycle pulse, result valid
//   result  selected result, held until the next accepted start
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             freeze,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [CW-1:0]      count_reg;
  logic [1:0]         op_reg;
  logic [WIDTH-1:0]   divisor_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [2*WIDTH-1:0] prod_reg;
  logic [WIDTH:0]     rem_reg;
  logic [WIDTH-1:0]   quo_reg;
  logic [WIDTH-1:0]   result_reg;

  logic               accept;
  logic               last_iter;
  logic               load_result;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   result_sel;

  assign last_iter = (count_reg == CW'(WIDTH - 1));

  // One iteration of each algorithm, computed every cycle. Both run in
  // parallel; the latched op only chooses which one feeds the result.
  always_comb begin
    prod_next = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
    rem_shift = {rem_reg[WIDTH-1:0], quo_reg[WIDTH-1]};
    rem_next  = rem_shift;
    quo_next  = {quo_reg[WIDTH-2:0], 1'b0};
    // With a zero divisor the compare always succeeds, so the quotient
    // fills with ones and the remainder ends up equal to the dividend.
    if (rem_shift >= {1'b0, divisor_reg}) begin
      rem_next = rem_shift - {1'b0, divisor_reg};
      quo_next = {quo_reg[WIDTH-2:0], 1'b1};
    end
  end

  // Result is taken from the final iteration's next values so it can be
  // registered on the same edge that enters DONE.
  always_comb begin
    result_sel = prod_next[WIDTH-1:0];
    case (op_reg)
      2'b00:   result_sel = prod_next[WIDTH-1:0];
      2'b01:   result_sel = prod_next[2*WIDTH-1:WIDTH];
      2'b10:   result_sel = quo_next;
      default: result_sel = rem_next[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    busy        = 1'b0;
    done        = 1'b0;
    freeze      = 1'b0;
    accept      = 1'b0;
    load_result = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && !flush) begin
          accept     = 1'b1;
          freeze     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy   = 1'b1;
        freeze = 1'b1;
        if (flush) begin
          state_next = IDLE;
        end else if (last_iter) begin
          load_result = 1'b1;
          state_next  = DONE;
        end
      end
      DONE: begin
        // start here still belongs to the instruction that just finished.
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (rst) begin
      freeze = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg   <= '0;
      op_reg      <= '0;
      divisor_reg <= '0;
      mplier_reg  <= '0;
      mcand_reg   <= '0;
      prod_reg    <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      result_reg  <= '0;
    end else if (accept) begin
      count_reg   <= '0;
      op_reg      <= op;
      divisor_reg <= b;
      mplier_reg  <= b;
      mcand_reg   <= {{WIDTH{1'b0}}, a};
      prod_reg    <= '0;
      rem_reg     <= '0;
      quo_reg     <= a;
    end else if (state_reg == RUN) begin
      count_reg  <= count_reg + CW'(1);
      prod_reg   <= prod_next;
      mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
      mcand_reg  <= {mcand_reg[2*WIDTH-2:0], 1'b0};
      rem_reg    <= rem_next;
      quo_reg    <= quo_next;
      if (load_result) begin
        result_reg <= result_sel;
      end
    end
  end

  assign result = result_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer: table of back-to-back operations with
// hand-computed results, followed by flush and mid-run reset sequences.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         busy;
  logic         freeze;
  logic         done;
  logic [W-1:0] result;

  int total = 0;
  int bad   = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .freeze (freeze),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] a_late;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Cycle 0 drives the command; cycles 1..W+1 scramble the inputs and
  // expect RUN, then DONE with the result at cycle W+1.
  task automatic run_op(input vec_t v);
    next_cycle();
    start = 1'b1;
    flush = 1'b0;
    op    = v.op;
    a     = v.a;
    b     = v.b;
    sample();
    chk({v.name, " c0 freeze"}, W'(freeze), W'(1));
    chk({v.name, " c0 busy"}, W'(busy), W'(0));
    for (int c = 1; c <= W + 1; c++) begin
      next_cycle();
      a  = v.a_late;
      b  = ~v.b;
      op = ~v.op;
      sample();
      if (c <= W) begin
        if (done !== 1'b0) chk({v.name, " early done"}, W'(done), W'(0));
        if (c == 1 || c == W) begin
          chk({v.name, " run busy"}, W'(busy), W'(1));
          chk({v.name, " run freeze"}, W'(freeze), W'(1));
        end
      end else begin
        chk({v.name, " done"}, W'(done), W'(1));
        chk({v.name, " done freeze"}, W'(freeze), W'(0));
        chk({v.name, " done busy"}, W'(busy), W'(0));
        chk({v.name, " result"}, result, v.exp);
      end
    end
    $display("op %s: op=%0d a=%h b=%h result=%h expected=%h", v.name, v.op, v.a, v.b, result, v.exp);
  endtask

  initial begin
    logic [W-1:0] prev;
    int pulses;
    vec_t rec;

    vecs[0]  = '{"mul7x6",   2'b00, 32'd7,        32'd6,        32'd7,  32'd42};
    vecs[1]  = '{"mulh_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,  32'hFFFFFFFE};
    vecs[2]  = '{"mull_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,  32'h00000001};
    vecs[3]  = '{"divq",     2'b10, 32'd100,      32'd7,        32'd1,  32'd14};
    vecs[4]  = '{"divr",     2'b11, 32'd100,      32'd7,        32'd1,  32'd2};
    vecs[5]  = '{"div0q",    2'b10, 32'h1234,     32'd0,        32'd5,  32'hFFFFFFFF};
    vecs[6]  = '{"div0r",    2'b11, 32'h1234,     32'd0,        32'd5,  32'h00001234};
    vecs[7]  = '{"a_change", 2'b00, 32'd9,        32'd5,        32'd3,  32'd45};
    vecs[8]  = '{"mulh_sh",  2'b01, 32'h12345678, 32'h10,       32'd0,  32'h00000001};
    vecs[9]  = '{"mull_sh",  2'b00, 32'h12345678, 32'h10,       32'd0,  32'h23456780};
    vecs[10] = '{"div_by1",  2'b10, 32'hFFFFFFFF, 32'd1,        32'd0,  32'hFFFFFFFF};
    vecs[11] = '{"rem_big",  2'b11, 32'hFFFFFFFF, 32'h10,       32'd0,  32'h0000000F};

    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    next_cycle();
    next_cycle();
    sample();
    chk("reset freeze", W'(freeze), W'(0));
    next_cycle();
    rst = 1'b0;
    sample();
    chk("reset busy", W'(busy), W'(0));
    chk("reset done", W'(done), W'(0));
    chk("reset result", result, W'(0));
    chk("reset freeze idle", W'(freeze), W'(0));

    // Back-to-back: each command is accepted the cycle after the previous DONE.
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i]);
    end
    prev = vecs[11].exp;

    next_cycle();
    start = 1'b0;
    sample();
    chk("idle busy", W'(busy), W'(0));
    chk("idle freeze", W'(freeze), W'(0));
    chk("idle result hold", result, prev);

    // Flush at RUN cycle 10, with start held alongside flush afterwards.
    next_cycle();
    start = 1'b1;
    op    = 2'b00;
    a     = 32'd7;
    b     = 32'd6;
    sample();
    chk("flush c0 freeze", W'(freeze), W'(1));
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      if (c == 10) flush = 1'b1;
      sample();
    end
    chk("flush c10 busy", W'(busy), W'(1));
    next_cycle();
    sample();
    chk("flush idle busy", W'(busy), W'(0));
    chk("flush idle freeze", W'(freeze), W'(0));
    chk("flush idle done", W'(done), W'(0));
    chk("flush result hold", result, prev);
    next_cycle();
    sample();
    chk("flush blocks accept", W'(busy), W'(0));
    flush  = 1'b0;
    start  = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      sample();
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    chk("flush no done", W'(pulses), W'(0));
    chk("flush result final", result, prev);
    $display("flush seq: result=%h expected=%h", result, prev);

    // Reset asserted at RUN cycle 20.
    next_cycle();
    start = 1'b1;
    op    = 2'b01;
    a     = 32'hDEADBEEF;
    b     = 32'h00000100;
    sample();
    for (int c = 1; c <= 20; c++) begin
      next_cycle();
      if (c == 20) begin
        rst   = 1'b1;
        start = 1'b0;
      end
      sample();
    end
    chk("rst freeze during", W'(freeze), W'(0));
    next_cycle();
    rst = 1'b0;
    sample();
    chk("rst busy", W'(busy), W'(0));
    chk("rst done", W'(done), W'(0));
    chk("rst result", result, W'(0));
    chk("rst freeze", W'(freeze), W'(0));
    $display("reset seq: busy=%0d done=%0d result=%h", busy, done, result);

    rec = '{"after_rst", 2'b00, 32'd3, 32'd5, 32'd8, 32'd15};
    run_op(rec);
    next_cycle();
    start = 1'b0;
    sample();
    chk("final idle busy", W'(busy), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative 32-bit unsigned multiply/divide unit with its own sequencing FSM, attached beside the ALU in the execute stage. When the instruction in EXE carries a mul/div command, the block accepts the already-forwarded operands, runs 32 shift-add or restoring-subtract iterations, and drives `freeze` to stall the pipeline. In the final cycle it releases the stall and presents the result, so the EXE/MEM register captures it on the same edge the instruction advances.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width; the iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  EXE instruction is a mul/div op; held high while that instruction sits in EXE.
- `op`  in  2  00 = MULU low word, 01 = MULU high word, 10 = DIVU quotient, 11 = DIVU remainder.
- `a`  in  WIDTH  operand 1 (forwarded Val1).
- `b`  in  WIDTH  operand 2 (forwarded Val2).
- `flush`  in  1  abort the current operation (branch taken / pipeline flush).
- `busy`  out  1  high in RUN.
- `freeze`  out  1  pipeline stall request, combinational.
- `done`  out  1  one-cycle pulse, result valid.
- `result`  out  WIDTH  selected result; holds until the next accepted start.

## Operation
- FSM states are IDLE, RUN and DONE. Reset enters IDLE, with `busy`=0, `done`=0, `result`=0, count=0 and internal registers=0.
- IDLE: if `start` is high and `flush` is low, latch `a`, `b` and `op`, clear the accumulators, set count=0, and go to RUN. Otherwise stay in IDLE.
- RUN: each cycle performs one iteration and increments count. After the iteration with count=WIDTH-1, go to DONE.
- Multiply (shift-add):
  - Use a 2·WIDTH product register P and a multiplier shift register.
  - Each cycle, if the multiplier LSB is 1, add the shifted multiplicand into P.
  - Shift the multiplier right and the multiplicand left.
  - Arithmetic is modulo 2^(2·WIDTH). No overflow is flagged.
- Divide (restoring):
  - Use a WIDTH+1-bit remainder R and a quotient Q.
  - Each cycle: R = {R, Q[MSB]}, Q <<= 1. If R ≥ b, set R −= b and Q[0] = 1.
- Divide by zero (`b`=0 latched): run the full latency anyway. Quotient = all ones, remainder = latched `a`. This falls out of the algorithm naturally and must be preserved.
- DONE: `done`=1. `result` is loaded on the RUN→DONE edge, selected by the latched `op`. Next state is IDLE unconditionally.
- `start` in DONE is ignored. It is the same instruction, which leaves EXE at the end of DONE.
- `start` in RUN is ignored, since operands are already latched.
- `freeze` = (IDLE & `start` & ~`flush`) | RUN. It is 0 in DONE and 0 during reset.
- `flush`:
  - In RUN, go to IDLE on the next edge. No `done` pulse; `result` is unchanged.
  - In DONE, it has no effect (result still presented, state goes to IDLE).
  - In IDLE, it blocks acceptance.
- `rst` has priority over `flush` and `start`. Reset mid-RUN returns to IDLE on the next edge with all outputs at their reset values.

## Timing
- Cycle 0 (IDLE, `start`=1): `freeze`=1, operands sampled at the end of the cycle.
- Cycles 1..WIDTH (RUN): `busy`=1, `freeze`=1.
- Cycle WIDTH+1 (DONE): `done`=1, `result` valid, `freeze`=0. The pipeline advances at the end of this cycle.
- Total EXE occupancy is WIDTH+2 cycles per mul/div instruction. A back-to-back mul/div is accepted in the first IDLE cycle after DONE.
- Operands `a` and `b` may change after cycle 0 without effect.
- `result` is registered. `done` and `busy` are registered-state decodes. `freeze` is combinational from `start`, `flush` and the state.

## Test plan
- Reset, then `start` with op=00, a=7, b=6: `freeze`=1 for cycles 0..32, `done`=1 only at cycle 33, `result`=42.
- op=01, a=0xFFFFFFFF, b=0xFFFFFFFF: `result`=0xFFFFFFFE at `done`. Re-run with op=00: `result`=0x00000001.
- op=10 then op=11 back-to-back, a=100, b=7: first `done` gives 14, second `start` accepted the cycle after DONE, second `done` gives 2 exactly 34 cycles later.
- Divide by zero, op=10 then op=11, a=0x1234, b=0: results 0xFFFFFFFF and 0x1234, latency unchanged (`done` at cycle 33).
- `flush` at RUN cycle 10: next cycle IDLE, `busy`=0, `freeze`=0, no `done` pulse, `result` keeps its prior value. A `start` held together with `flush` in IDLE is not accepted.
- Operands changed after cycle 0 (a=9→3) still give the result of a=9. `rst` asserted at RUN cycle 20 gives `busy`=0, `done`=0, `result`=0, `freeze`=0 on the next cycle.
